// File: rtl/gw_jtag_pkg.sv
// Shared types and constants for the GW_JTAG user data-register bridge.
//   dr_state_t   : per-channel scan state (IDLE, SHIFT, HOLD)
//   cnt_w()      : width of a bit counter that must hold 0..w+1
//   MAX_CH       : upper bound on the number of user channels
//   MAX_DR_WIDTH : upper bound on the per-channel register width
package gw_jtag_pkg;

  localparam int MAX_CH       = 8;
  localparam int MAX_DR_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } dr_state_t;

  // The counter saturates at w+1, so it needs to represent w+2 distinct values.
  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/gw_jtag_dr_chan.sv
// One user data-register channel in the TCK domain.
//   tck_i, rst_n_i    : JTAG clock, asynchronous active-low reset
//   tlr_i             : test-logic-reset, returns the channel to IDLE
//   tdi_i             : serial data in
//   shift_capture_i   : shift/capture level from the primitive
//   cap_edge_i        : shift_capture_i rising edge (shared detector in top)
//   upd_edge_i        : update_i rising edge (shared detector in top)
//   enable_i          : this channel is selected
//   cap_data_i        : parallel status word loaded on capture
//   err_clr_i         : clears the sticky length error
//   tdo_o             : serial data out (LSB of the shift register)
//   upd_data_o        : last accepted update word
//   upd_valid_o       : one-cycle pulse when upd_data_o is loaded
//   len_err_o         : sticky length-mismatch flag
module gw_jtag_dr_chan
  import gw_jtag_pkg::*;
#(
  parameter int DR_WIDTH     = 32,
  parameter bit LENGTH_CHECK = 1'b1
) (
  input  logic                tck_i,
  input  logic                rst_n_i,
  input  logic                tlr_i,
  input  logic                tdi_i,
  input  logic                shift_capture_i,
  input  logic                cap_edge_i,
  input  logic                upd_edge_i,
  input  logic                enable_i,
  input  logic [DR_WIDTH-1:0] cap_data_i,
  input  logic                err_clr_i,
  output logic                tdo_o,
  output logic [DR_WIDTH-1:0] upd_data_o,
  output logic                upd_valid_o,
  output logic                len_err_o
);

  localparam int             CW       = cnt_w(DR_WIDTH);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DR_WIDTH);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(DR_WIDTH + 1);

  dr_state_t           state_q, state_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DR_WIDTH-1:0] upd_q, upd_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                set_err;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    upd_d   = upd_q;
    valid_d = 1'b0;
    err_d   = err_q;
    set_err = 1'b0;

    if (tlr_i) begin
      // Reset of the TAP wins over everything; the published word and the
      // sticky error survive it.
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable_i && cap_edge_i) begin
            shift_d = cap_data_i;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        // An update arriving straight from SHIFT is handled like one from HOLD.
        SHIFT, HOLD: begin
          if (!enable_i) begin
            state_d = IDLE;
          end else if (upd_edge_i) begin
            state_d = IDLE;
            if (!LENGTH_CHECK || cnt_q == CNT_FULL) begin
              upd_d   = shift_q;
              valid_d = 1'b1;
            end else begin
              set_err = 1'b1;
            end
          end else if (shift_capture_i) begin
            // Re-entering Shift-DR from HOLD shifts straight away, no re-capture.
            shift_d = {tdi_i, shift_q[DR_WIDTH-1:1]};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
            state_d = SHIFT;
          end else begin
            state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
      // A new error wins over a clear in the same cycle.
      err_d = set_err | (err_q & ~err_clr_i);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge tck_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      upd_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign tdo_o       = shift_q[0];
  assign upd_data_o  = upd_q;
  assign upd_valid_o = valid_q;
  assign len_err_o   = err_q;

endmodule

// File: rtl/gw_jtag_user_dr.sv
// Multi-channel JTAG user data-register bridge behind the GW_JTAG primitive.
//   tck_i, rst_n_i   : JTAG clock, asynchronous active-low reset
//   tlr_i            : test-logic-reset from the primitive
//   tdi_i            : serial data in, shared by all channels
//   shift_capture_i  : primitive shift_dr_capture_dr_o
//   update_i         : primitive update_dr_o
//   enable_i         : per-channel select (one-hot or zero)
//   tdo_o            : per-channel serial out
//   cap_data_i       : capture words, channel k at [k*DR_WIDTH +: DR_WIDTH]
//   upd_data_o       : accepted update words, same packing
//   upd_valid_o      : per-channel one-cycle update pulse
//   len_err_o        : per-channel sticky length-mismatch flag
//   err_clr_i        : per-channel error clear
module gw_jtag_user_dr
  import gw_jtag_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DR_WIDTH     = 32,
  parameter bit LENGTH_CHECK = 1'b1
) (
  input  logic                       tck_i,
  input  logic                       rst_n_i,
  input  logic                       tlr_i,
  input  logic                       tdi_i,
  input  logic                       shift_capture_i,
  input  logic                       update_i,
  input  logic [NUM_CH-1:0]          enable_i,
  output logic [NUM_CH-1:0]          tdo_o,
  input  logic [NUM_CH*DR_WIDTH-1:0] cap_data_i,
  output logic [NUM_CH*DR_WIDTH-1:0] upd_data_o,
  output logic [NUM_CH-1:0]          upd_valid_o,
  output logic [NUM_CH-1:0]          len_err_o,
  input  logic [NUM_CH-1:0]          err_clr_i
);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("gw_jtag_user_dr: NUM_CH=%0d out of range 1..%0d", NUM_CH, MAX_CH);
  end
  if (DR_WIDTH < 2 || DR_WIDTH > MAX_DR_WIDTH) begin : g_bad_width
    $error("gw_jtag_user_dr: DR_WIDTH=%0d out of range 2..%0d", DR_WIDTH, MAX_DR_WIDTH);
  end

  // Previous-cycle copies of the shared control levels, for edge detection.
  logic sc_q;
  logic upd_q;

  always_ff @(posedge tck_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sc_q  <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      sc_q  <= shift_capture_i;
      upd_q <= update_i;
    end
  end

  logic cap_edge;
  logic upd_edge;

  assign cap_edge = shift_capture_i & ~sc_q;
  assign upd_edge = update_i & ~upd_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    gw_jtag_dr_chan #(
      .DR_WIDTH     (DR_WIDTH),
      .LENGTH_CHECK (LENGTH_CHECK)
    ) u_chan (
      .tck_i           (tck_i),
      .rst_n_i         (rst_n_i),
      .tlr_i           (tlr_i),
      .tdi_i           (tdi_i),
      .shift_capture_i (shift_capture_i),
      .cap_edge_i      (cap_edge),
      .upd_edge_i      (upd_edge),
      .enable_i        (enable_i[k]),
      .cap_data_i      (cap_data_i[k*DR_WIDTH +: DR_WIDTH]),
      .err_clr_i       (err_clr_i[k]),
      .tdo_o           (tdo_o[k]),
      .upd_data_o      (upd_data_o[k*DR_WIDTH +: DR_WIDTH]),
      .upd_valid_o     (upd_valid_o[k]),
      .len_err_o       (len_err_o[k])
    );
  end

endmodule

// File: tb/tb_gw_jtag_user_dr.sv
// Self-checking bench for gw_jtag_user_dr (NUM_CH=2, DR_WIDTH=8).
// Two instances share all stimulus: dut checks lengths, dut_nc does not.
// Expected update words are queued as updates are driven and popped when
// the DUTs pulse upd_valid_o.
module tb_gw_jtag_user_dr;

  localparam int NCH = 2;
  localparam int W   = 8;

  logic             tck;
  logic             rst_n;
  logic             tlr;
  logic             tdi;
  logic             shift_capture;
  logic             update;
  logic [NCH-1:0]   enable;
  logic [NCH*W-1:0] cap_data;
  logic [NCH-1:0]   err_clr;

  logic [NCH-1:0]   tdo, tdo_nc;
  logic [NCH*W-1:0] upd_data, upd_data_nc;
  logic [NCH-1:0]   upd_valid, upd_valid_nc;
  logic [NCH-1:0]   len_err, len_err_nc;

  gw_jtag_user_dr #(.NUM_CH(NCH), .DR_WIDTH(W), .LENGTH_CHECK(1'b1)) dut (
    .tck_i(tck), .rst_n_i(rst_n), .tlr_i(tlr), .tdi_i(tdi),
    .shift_capture_i(shift_capture), .update_i(update), .enable_i(enable),
    .tdo_o(tdo), .cap_data_i(cap_data), .upd_data_o(upd_data),
    .upd_valid_o(upd_valid), .len_err_o(len_err), .err_clr_i(err_clr)
  );

  gw_jtag_user_dr #(.NUM_CH(NCH), .DR_WIDTH(W), .LENGTH_CHECK(1'b0)) dut_nc (
    .tck_i(tck), .rst_n_i(rst_n), .tlr_i(tlr), .tdi_i(tdi),
    .shift_capture_i(shift_capture), .update_i(update), .enable_i(enable),
    .tdo_o(tdo_nc), .cap_data_i(cap_data), .upd_data_o(upd_data_nc),
    .upd_valid_o(upd_valid_nc), .len_err_o(len_err_nc), .err_clr_i(err_clr)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t q_nc[$];

  // Reference model of each channel's shift register and counter.
  logic [7:0] m_sr     [NCH];
  int         m_cnt    [NCH];
  logic [7:0] m_upd    [NCH];
  logic [7:0] m_upd_nc [NCH];
  logic       m_err    [NCH];

  // Scoreboard monitors: every pulse must match the oldest queued expectation.
  always @(negedge tck) begin
    exp_t e;
    if (rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        if (upd_valid[k]) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL upd_valid_unexpected: ch%0d pulsed data %h, expected no pulse", k, upd_data[k*W +: W]);
          end else begin
            e = q.pop_front();
            if (e.ch != k || upd_data[k*W +: W] !== e.data) begin
              errors++;
              $display("FAIL upd_word: got ch%0d data %h, expected ch%0d data %h", k, upd_data[k*W +: W], e.ch, e.data);
            end
          end
        end
      end
    end
  end

  always @(negedge tck) begin
    exp_t e;
    if (rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        if (upd_valid_nc[k]) begin
          checks++;
          if (q_nc.size() == 0) begin
            errors++;
            $display("FAIL nc_upd_valid_unexpected: ch%0d pulsed data %h, expected no pulse", k, upd_data_nc[k*W +: W]);
          end else begin
            e = q_nc.pop_front();
            if (e.ch != k || upd_data_nc[k*W +: W] !== e.data) begin
              errors++;
              $display("FAIL nc_upd_word: got ch%0d data %h, expected ch%0d data %h", k, upd_data_nc[k*W +: W], e.ch, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic capture(input int ch, input logic [7:0] cap);
    enable              = NCH'(1 << ch);
    cap_data[ch*W +: W] = cap;
    shift_capture       = 1'b1;
    tick();
    m_sr[ch]  = cap;
    m_cnt[ch] = 0;
  endtask

  task automatic shift(input int ch, input logic [63:0] d, input int n, input bit chk_tdo);
    shift_capture = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (chk_tdo) begin
        checks++;
        if (tdo[ch] !== m_sr[ch][0]) begin
          errors++;
          $display("FAIL shift_tdo ch%0d bit%0d: got %b expected %b", ch, i, tdo[ch], m_sr[ch][0]);
        end
      end
      tdi = d[i];
      tick();
      m_sr[ch]  = {d[i], m_sr[ch][7:1]};
      m_cnt[ch] = (m_cnt[ch] + 1 > W + 1) ? W + 1 : m_cnt[ch] + 1;
    end
  endtask

  task automatic pause(input int n);
    shift_capture = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_update(input int ch, input int hold);
    if (m_cnt[ch] == W) begin
      q.push_back('{ch, m_sr[ch]});
      m_upd[ch] = m_sr[ch];
    end else begin
      m_err[ch] = 1'b1;
    end
    q_nc.push_back('{ch, m_sr[ch]});
    m_upd_nc[ch] = m_sr[ch];
    update = 1'b1;
    repeat (hold) tick();
    update = 1'b0;
    tick();
  endtask

  task automatic clear_err(input int ch);
    err_clr = NCH'(1 << ch);
    tick();
    err_clr   = '0;
    m_err[ch] = 1'b0;
  endtask

  task automatic reset_model();
    for (int k = 0; k < NCH; k++) begin
      m_sr[k] = '0; m_cnt[k] = 0; m_upd[k] = '0; m_upd_nc[k] = '0; m_err[k] = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; tlr = 0; tdi = 0; shift_capture = 0; update = 0;
    enable = '0; err_clr = '0; cap_data = 16'hFFFF;
    reset_model();
    #17;
    checks++;
    if (upd_data !== '0 || upd_valid !== '0 || len_err !== '0 || tdo !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data %h valid %b err %b tdo %b, expected all zero", upd_data, upd_valid, len_err, tdo);
    end
    checks++;
    if (upd_data_nc !== '0 || tdo_nc !== '0 || len_err_nc !== '0) begin
      errors++;
      $display("FAIL reset_outputs_nc: got data %h tdo %b err %b, expected all zero", upd_data_nc, tdo_nc, len_err_nc);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_scan();
    logic [7:0] exp_tdo;
    logic [7:0] din;
    exp_tdo = 8'hA5;  // tdo shows capture bits LSB first: 1,0,1,0,0,1,0,1
    din     = 8'h3C;
    cap_data[15:8] = 8'h5A;
    capture(0, 8'hA5);
    for (int i = 0; i < W; i++) begin
      checks++;
      if (tdo[0] !== exp_tdo[i]) begin
        errors++;
        $display("FAIL basic_tdo bit%0d: got %b expected %b", i, tdo[0], exp_tdo[i]);
      end
      checks++;
      if (tdo[1] !== 1'b0) begin
        errors++;
        $display("FAIL basic_ch1_idle_tdo bit%0d: got %b expected 0", i, tdo[1]);
      end
      tdi = din[i];
      tick();
    end
    m_sr[0] = din; m_cnt[0] = W;
    pause(1);
    do_update(0, 2);  // update held two cycles: still a single pulse
    checks++;
    if (upd_data[7:0] !== 8'h3C || upd_data[15:8] !== 8'h00 || len_err !== '0) begin
      errors++;
      $display("FAIL basic_result: got data %h err %b, expected data 003c err 00", upd_data, len_err);
    end
  endtask

  task automatic test_pause_resume();
    capture(0, 8'hFF);
    shift(0, 64'h96, 3, 1'b1);
    pause(4);
    checks++;
    if (tdo[0] !== m_sr[0][0]) begin
      errors++;
      $display("FAIL pause_tdo_held: got %b expected %b", tdo[0], m_sr[0][0]);
    end
    shift(0, 64'h96 >> 3, 5, 1'b1);
    pause(1);
    do_update(0, 1);
    checks++;
    if (upd_data[7:0] !== 8'h96 || len_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL pause_result: got data %h err %b, expected data 96 err 0", upd_data[7:0], len_err[0]);
    end
  endtask

  task automatic test_length_error();
    // Short scan: 7 bits.
    capture(0, 8'h11);
    shift(0, 64'h7E, 7, 1'b0);
    pause(1);
    do_update(0, 1);
    checks++;
    if (len_err[0] !== 1'b1 || upd_data[7:0] !== 8'h96) begin
      errors++;
      $display("FAIL short_scan: got err %b data %h, expected err 1 data 96", len_err[0], upd_data[7:0]);
    end
    checks++;
    if (len_err_nc[0] !== 1'b0 || upd_data_nc[7:0] !== m_upd_nc[0]) begin
      errors++;
      $display("FAIL short_scan_nc: got err %b data %h, expected err 0 data %h", len_err_nc[0], upd_data_nc[7:0], m_upd_nc[0]);
    end
    clear_err(0);
    checks++;
    if (len_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", len_err[0]);
    end
    // Overshift: 9 bits saturates the counter and is still an error.
    capture(0, 8'h22);
    shift(0, 64'h1C3, 9, 1'b0);
    pause(1);
    do_update(0, 1);
    checks++;
    if (len_err[0] !== 1'b1 || upd_data[7:0] !== 8'h96) begin
      errors++;
      $display("FAIL long_scan: got err %b data %h, expected err 1 data 96", len_err[0], upd_data[7:0]);
    end
    checks++;
    if (upd_data_nc[7:0] !== m_upd_nc[0]) begin
      errors++;
      $display("FAIL long_scan_nc: got data %h expected %h", upd_data_nc[7:0], m_upd_nc[0]);
    end
    clear_err(0);
  endtask

  task automatic test_err_clear_race();
    capture(0, 8'h33);
    shift(0, 64'h15, 5, 1'b0);
    pause(1);
    q_nc.push_back('{0, m_sr[0]});
    m_upd_nc[0] = m_sr[0];
    update  = 1'b1;
    err_clr = 2'b01;
    tick();
    checks++;
    if (len_err[0] !== 1'b1) begin
      errors++;
      $display("FAIL race_set_wins: got %b expected 1", len_err[0]);
    end
    tick();  // clear alone, update still held (no new edge)
    checks++;
    if (len_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL race_clear_after: got %b expected 0", len_err[0]);
    end
    update  = 1'b0;
    err_clr = '0;
    tick();
  endtask

  task automatic test_tlr_mid_scan();
    capture(0, 8'h01);
    shift(0, 64'h00, 7, 1'b0);
    pause(1);
    do_update(0, 1);  // leaves a sticky error that must survive tlr
    capture(0, 8'hC3);
    shift(0, 64'h0F, 4, 1'b0);
    tlr = 1'b1;
    tick();
    tlr = 1'b0;
    checks++;
    if (tdo[0] !== 1'b0 || len_err[0] !== 1'b1) begin
      errors++;
      $display("FAIL tlr_state: got tdo %b err %b, expected tdo 0 err 1", tdo[0], len_err[0]);
    end
    pause(1);
    update = 1'b1; tick(); update = 1'b0; tick();
    checks++;
    if (upd_data[7:0] !== m_upd[0] || upd_data_nc[7:0] !== m_upd_nc[0]) begin
      errors++;
      $display("FAIL tlr_no_update: got %h/%h expected %h/%h", upd_data[7:0], upd_data_nc[7:0], m_upd[0], m_upd_nc[0]);
    end
    clear_err(0);
    capture(0, 8'h0F);
    shift(0, 64'hE1, 8, 1'b1);
    pause(1);
    do_update(0, 1);
    checks++;
    if (upd_data[7:0] !== 8'hE1) begin
      errors++;
      $display("FAIL tlr_next_scan: got %h expected e1", upd_data[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    capture(1, 8'h3C);
    shift(1, 64'hA7, 8, 1'b1);
    pause(1);
    do_update(1, 1);
    capture(1, 8'hA7);
    shift(1, 64'h5B, 8, 1'b1);
    pause(1);
    do_update(1, 1);
    checks++;
    if (upd_data[15:8] !== 8'h5B || upd_data[7:0] !== 8'hE1) begin
      errors++;
      $display("FAIL b2b_result: got %h expected 5be1", upd_data);
    end
    checks++;
    if (q.size() != 0 || q_nc.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending: got %0d/%0d queued updates, expected 0/0", q.size(), q_nc.size());
    end
  endtask

  task automatic test_async_reset();
    capture(0, 8'hAA);
    shift(0, 64'h05, 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (upd_data !== '0 || upd_valid !== '0 || len_err !== '0 || tdo !== '0 || upd_data_nc !== '0) begin
      errors++;
      $display("FAIL async_reset: got data %h valid %b err %b tdo %b nc %h, expected zero", upd_data, upd_valid, len_err, tdo, upd_data_nc);
    end
    shift_capture = 1'b0; enable = '0;
    reset_model();
    #3;
    rst_n = 1'b1;
    tick();
    // Enable dropped during HOLD: no update, no error.
    capture(0, 8'h55);
    shift(0, 64'h33, 8, 1'b0);
    pause(1);
    enable = '0;
    tick();
    enable = 2'b01;
    update = 1'b1; tick(); update = 1'b0; tick();
    enable = '0;
    checks++;
    if (len_err[0] !== 1'b0 || upd_data[7:0] !== 8'h00 || upd_data_nc[7:0] !== 8'h00) begin
      errors++;
      $display("FAIL enable_drop: got err %b data %h nc %h, expected 0 00 00", len_err[0], upd_data[7:0], upd_data_nc[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_pause_resume();
    test_length_error();
    test_err_clear_race();
    test_tlr_mid_scan();
    test_back_to_back();
    test_async_reset();
    repeat (3) tick();
    checks++;
    if (q.size() != 0 || q_nc.size() != 0) begin
      errors++;
      $display("FAIL final_pending: got %0d/%0d queued updates, expected 0/0", q.size(), q_nc.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
